sha256_round_ctrl: RTL and testbench
====================================

Name: sha256_round_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath: the eight 32-bit working registers a..h, the eight hash registers H0..H7 and the message scheduler.
- Accepts 512-bit blocks through a valid/ready handshake and generates per-cycle load and round enables, the round index and round constant K[t].
- Tracks first/last block of a message so multi-block messages chain correctly.
- Presents the digest through a valid/ready handshake.

Parameters:
- ROUNDS, 64, number of compression rounds per block (reduced values for simulation only).
- CNT_W, 6, round counter width; must satisfy 2^CNT_W >= ROUNDS.

Ports:
- CLK  input  1  clock
- RST  input  1  reset: asynchronous, active-high; clock CLK
- abort  input  1  synchronous abort; returns to IDLE and forgets message context
- blk_valid  input  1  message block (in scheduler) is available
- blk_last  input  1  qualifies blk_valid: final block of the message
- blk_ready  output  1  controller can accept a block
- init_sel  output  1  a..h / H source mux: 1 = IV constants, 0 = H registers
- hash_init  output  1  load H0..H7 with IV (first block only)
- ld_work  output  1  load a..h from init_sel source
- rnd_en  output  1  enable one round update of a..h and scheduler shift
- rnd_idx  output  CNT_W  current round t
- w_sel  output  1  0 = W[t] from block words (t<16), 1 = scheduled expansion
- k_t  output  32  round constant K[rnd_idx]
- ld_hash  output  1  H_i <= H_i + working var (mod 2^32)
- digest_valid  output  1  H0..H7 hold final digest
- digest_ready  input  1  consumer accepts digest
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, ROUND, UPDATE, OUT. Outputs decode from registered state/counter only; no input-to-output combinational path.
- Reset (RST high, async): state=IDLE, rnd_idx=0, first_q=1, last_q=0. blk_ready=1; all other outputs 0. k_t=K[0]=0x428a2f98.
- IDLE: blk_ready=1. On blk_valid&blk_ready: last_q<=blk_last; go LOAD.
- LOAD (1 cycle): ld_work=1. init_sel=first_q. hash_init=first_q. Go ROUND with rnd_idx=0.
- ROUND (ROUNDS cycles): rnd_en=1, w_sel=(rnd_idx>=16), k_t=K[rnd_idx]. rnd_idx increments each cycle. When rnd_idx==ROUNDS-1, go UPDATE; rnd_idx wraps to 0.
- UPDATE (1 cycle): ld_hash=1.
  - If last_q: first_q<=1, go OUT.
  - Else: first_q<=0, go IDLE.
- OUT: digest_valid=1, held stable until digest_ready. On digest_valid&digest_ready, go IDLE same edge. digest_ready while not in OUT is ignored.
- Timing (ROUNDS=64, accept edge = cycle 0):
  - LOAD at cycle 1.
  - Rounds at cycles 2..65.
  - UPDATE at cycle 66.
  - Then either digest_valid from cycle 67 (last block) or blk_ready from cycle 67 (non-last). Non-last throughput: 67 cycles/block.
- blk_valid in any state other than IDLE is ignored; blk_ready is low there.
- abort has priority over all transitions:
  - next state IDLE, rnd_idx=0, first_q=1.
  - No enables are asserted on the abort cycle's outputs after the edge.
  - abort in IDLE is harmless.
- Asynchronous RST mid-ROUND: immediate return to reset values. Datapath contents are don't-care.
- Simultaneous blk_valid and abort in IDLE: abort wins, block not accepted.
- K table: 64 standard FIPS 180-4 constants. Index out of range (ROUNDS<64 never reaches it) returns K[rnd_idx mod 64].

Decomposition:
- Shared package sha256_pkg contains:
  - state enum (IDLE, LOAD, ROUND, UPDATE, OUT)
  - ROUNDS default
  - IV constants H0..H7 (0x6a09e667 ... 0x5be0cd19)
  - K[0..63] table
- One sub-module sha256_k_rom: combinational 6-bit index to 32-bit K lookup, reused by any future unrolled datapath.

Test Plan:
- Reset then idle: RST pulse -> blk_ready=1, busy=0, rnd_idx=0, k_t=0x428a2f98, all enables 0.
- Single-block "abc": blk_valid+blk_last at cycle 0 -> the following all hold:
  - hash_init=ld_work=init_sel=1 at cycle 1.
  - rnd_en high for exactly 64 cycles; w_sel rises when rnd_idx=16; k_t=0xc67178f2 at rnd_idx=63.
  - ld_hash at cycle 66; digest_valid at 67.
  - With the reference datapath, digest = ba7816bf...f20015ad.
- Two-block message (first blk_last=0) -> second LOAD has init_sel=0, hash_init=0. Digest of the 56-char NIST vector = 248d6a61...19db06c1.
- Digest backpressure: digest_ready low 10 cycles -> digest_valid stays 1, blk_ready stays 0. Accepting edge returns IDLE next cycle.
- abort at rnd_idx=30 -> next cycle IDLE, rnd_en=0, rnd_idx=0. The next block gets init_sel=1.
- blk_valid asserted during ROUND and OUT -> ignored, no extra ld_work. ROUNDS=8 build completes UPDATE at cycle 10.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller states, control bundle, IV and round constants.
package sha256_pkg;

   localparam int unsigned ROUNDS_DEF = 64;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned K_IDX_W    = 6;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      ROUND  = 3'd2,
      UPDATE = 3'd3,
      OUT    = 3'd4
   } state_e;

   // One-bit controls driven towards the compression datapath
   typedef struct packed {
      logic blk_ready;
      logic init_sel;
      logic hash_init;
      logic ld_work;
      logic rnd_en;
      logic w_sel;
      logic ld_hash;
      logic digest_valid;
      logic busy;
   } ctrl_t;

   localparam logic [WORD_W-1:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [WORD_W-1:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, K[idx].
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [K_IDX_W-1:0] idx,
   output logic [WORD_W-1:0]  k_c
);

   assign k_c = K_TAB[idx];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, per-round enables, K[t], digest handshake.
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int unsigned ROUNDS = ROUNDS_DEF,
   parameter int unsigned CNT_W  = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             abort,
   input  logic             blk_valid,
   input  logic             blk_last,
   output logic             blk_ready,
   output logic             init_sel,
   output logic             hash_init,
   output logic             ld_work,
   output logic             rnd_en,
   output logic [CNT_W-1:0] rnd_idx,
   output logic             w_sel,
   output logic [31:0]      k_t,
   output logic             ld_hash,
   output logic             digest_valid,
   input  logic             digest_ready,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);
   localparam int unsigned      W_SCHED  = 16;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    rnd_q, rnd_d;
   logic                first_q, first_d;
   logic                last_q, last_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [WORD_W-1:0]   k_q, k_d;
   logic [K_IDX_W-1:0]  k_idx;

   // Index wraps modulo 64 when the counter is wider than the table
   assign k_idx = K_IDX_W'(rnd_d);

   sha256_k_rom u_k_rom (
      .idx (k_idx),
      .k_c (k_d)
   );

   // State, counter, message context and registered control outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q          <= IDLE;
         rnd_q            <= '0;
         first_q          <= 1'b1;
         last_q           <= 1'b0;
         ctrl_q           <= '0;
         ctrl_q.blk_ready <= 1'b1;
         k_q              <= K_TAB[0];
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         first_q <= first_d;
         last_q  <= last_d;
         ctrl_q  <= ctrl_d;
         k_q     <= k_d;
      end
   end

   // Next state; outputs are decoded from the next state so they land registered
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      first_d = first_q;
      last_d  = last_q;
      ctrl_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (blk_valid) begin
               last_d  = blk_last;
               state_d = LOAD;
            end
         end
         LOAD: begin
            rnd_d   = '0;
            state_d = ROUND;
         end
         ROUND: begin
            if (rnd_q == LAST_IDX) begin
               rnd_d   = '0;
               state_d = UPDATE;
            end else begin
               rnd_d = rnd_q + CNT_W'(1);
            end
         end
         UPDATE: begin
            first_d = last_q;
            state_d = last_q ? OUT : IDLE;
         end
         OUT: begin
            if (digest_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort discards the message in flight, including chaining context
      if (abort) begin
         state_d = IDLE;
         rnd_d   = '0;
         first_d = 1'b1;
         last_d  = 1'b0;
      end

      ctrl_d.busy = (state_d != IDLE);
      unique case (state_d)
         IDLE:   ctrl_d.blk_ready = 1'b1;
         LOAD: begin
            ctrl_d.ld_work   = 1'b1;
            ctrl_d.init_sel  = first_d;
            ctrl_d.hash_init = first_d;
         end
         ROUND: begin
            ctrl_d.rnd_en = 1'b1;
            ctrl_d.w_sel  = (32'(rnd_d) >= W_SCHED);
         end
         UPDATE: ctrl_d.ld_hash      = 1'b1;
         OUT:    ctrl_d.digest_valid = 1'b1;
         default: ctrl_d = '0;
      endcase
   end

   assign blk_ready    = ctrl_q.blk_ready;
   assign init_sel     = ctrl_q.init_sel;
   assign hash_init    = ctrl_q.hash_init;
   assign ld_work      = ctrl_q.ld_work;
   assign rnd_en       = ctrl_q.rnd_en;
   assign w_sel        = ctrl_q.w_sel;
   assign ld_hash      = ctrl_q.ld_hash;
   assign digest_valid = ctrl_q.digest_valid;
   assign busy         = ctrl_q.busy;
   assign rnd_idx      = rnd_q;
   assign k_t          = k_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: drives a reference SHA-256 datapath from the controller enables.
module tb_sha256_round_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        abort, blk_valid, blk_last, digest_ready;
   logic        blk_ready, init_sel, hash_init, ld_work, rnd_en, w_sel, ld_hash, digest_valid, busy;
   logic [5:0]  rnd_idx;
   logic [31:0] k_t;

   logic        bv8, dr8;
   logic        br8, is8, hi8, lw8, re8, ws8, lh8, dv8, busy8;
   logic [2:0]  ri8;
   logic [31:0] kt8;

   int checks   = 0;
   int failures = 0;
   int n_ld_work = 0;

   always #5 CLK = ~CLK;

   sha256_round_ctrl u_dut (
      .CLK(CLK), .RST(RST), .abort(abort), .blk_valid(blk_valid), .blk_last(blk_last),
      .blk_ready(blk_ready), .init_sel(init_sel), .hash_init(hash_init), .ld_work(ld_work),
      .rnd_en(rnd_en), .rnd_idx(rnd_idx), .w_sel(w_sel), .k_t(k_t), .ld_hash(ld_hash),
      .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
   );

   sha256_round_ctrl #(.ROUNDS(8), .CNT_W(3)) u_dut8 (
      .CLK(CLK), .RST(RST), .abort(1'b0), .blk_valid(bv8), .blk_last(1'b1),
      .blk_ready(br8), .init_sel(is8), .hash_init(hi8), .ld_work(lw8),
      .rnd_en(re8), .rnd_idx(ri8), .w_sel(ws8), .k_t(kt8), .ld_hash(lh8),
      .digest_valid(dv8), .digest_ready(dr8), .busy(busy8)
   );

   localparam logic [0:7][31:0] IV_B = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19 };
   localparam logic [0:15][31:0] BLK_ABC = {
      32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018 };
   localparam logic [0:15][31:0] BLK2_1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000 };
   localparam logic [0:15][31:0] BLK2_2 = {
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0 };
   localparam logic [255:0] DIG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_2BLK =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   // Reference datapath state
   logic [0:15][31:0] blkw;
   logic [15:0][31:0] win;
   logic [0:7][31:0]  hm;
   logic [0:7][31:0]  wk;
   logic [255:0]      exp_q[$];

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] cur_w(input logic sel, input logic [15:0][31:0] w,
                                         input logic [0:15][31:0] b, input logic [3:0] idx);
      logic [31:0] s0, s1;
      s0 = ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3);
      s1 = ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10);
      return sel ? (s1 + w[9] + s0 + w[0]) : b[idx];
   endfunction

   function automatic logic [0:7][31:0] round_f(input logic [0:7][31:0] s,
                                                input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1, t2;
      t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
   endfunction

   function automatic logic [0:7][31:0] add_h(input logic [0:7][31:0] h, input logic [0:7][31:0] v);
      logic [0:7][31:0] r;
      for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
      return r;
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%064h expected=%064h", tag, obs, exp);
      end
   endtask

   // Datapath model and scoreboard, both clocked by the controller outputs
   always @(posedge CLK) begin
      if (!RST) begin
         if (hash_init) hm <= IV_B;
         if (ld_work) begin
            wk <= init_sel ? IV_B : hm;
            n_ld_work <= n_ld_work + 1;
         end
         if (rnd_en) begin
            win <= {cur_w(w_sel, win, blkw, rnd_idx[3:0]), win[15:1]};
            wk  <= round_f(wk, k_t, cur_w(w_sel, win, blkw, rnd_idx[3:0]));
         end
         if (ld_hash) hm <= add_h(hm, wk);
         if (digest_valid && digest_ready) begin
            chk32("sb_expected_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk256("digest", hm, exp_q.pop_front());
         end
      end
   end

   task automatic send_block(input logic last);
      chk32("blk_ready_before_send", 32'(blk_ready), 32'd1);
      blk_valid = 1'b1;
      blk_last  = last;
      @(negedge CLK);
      blk_valid = 1'b0;
      blk_last  = 1'b0;
   endtask

   initial begin
      int n, nr, hc, dc;
      RST = 1'b1; abort = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; digest_ready = 1'b0;
      bv8 = 1'b0; dr8 = 1'b0; blkw = BLK_ABC;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      chk32("rst_blk_ready", 32'(blk_ready), 32'd1);
      chk32("rst_busy", 32'(busy), 32'd0);
      chk32("rst_rnd_idx", 32'(rnd_idx), 32'd0);
      chk32("rst_k_t", k_t, 32'h428a2f98);
      chk32("rst_enables", 32'({init_sel, hash_init, ld_work, rnd_en, w_sel, ld_hash, digest_valid}), 32'd0);

      // Single-block "abc", with ignored blk_valid during ROUND and OUT
      exp_q.push_back(DIG_ABC);
      send_block(1'b1);
      chk32("abc_ld_work", 32'(ld_work), 32'd1);
      chk32("abc_hash_init", 32'(hash_init), 32'd1);
      chk32("abc_init_sel", 32'(init_sel), 32'd1);
      nr = 0;
      for (int t = 0; t < 64; t++) begin
         @(negedge CLK);
         if (t == 5) blk_valid = 1'b1;
         if (rnd_en) nr++;
         chk32("abc_rnd_idx", 32'(rnd_idx), 32'(t));
         chk32("abc_w_sel", 32'(w_sel), 32'(t >= 16));
         if (t == 0)  chk32("abc_k0", k_t, 32'h428a2f98);
         if (t == 63) chk32("abc_k63", k_t, 32'hc67178f2);
         if (t == 20) chk32("round_blk_ready", 32'(blk_ready), 32'd0);
      end
      blk_valid = 1'b0;
      @(negedge CLK);
      chk32("abc_ld_hash_c66", 32'(ld_hash), 32'd1);
      chk32("abc_rnd_en_c66", 32'(rnd_en), 32'd0);
      chk32("abc_rnd_count", 32'(nr), 32'd64);
      @(negedge CLK);
      chk32("abc_digest_valid_c67", 32'(digest_valid), 32'd1);
      blk_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk32("bp_digest_valid", 32'(digest_valid), 32'd1);
         chk32("bp_blk_ready", 32'(blk_ready), 32'd0);
         chk32("bp_no_ld_work", 32'(ld_work), 32'd0);
      end
      blk_valid = 1'b0;
      digest_ready = 1'b1;
      @(negedge CLK);
      digest_ready = 1'b0;
      chk32("bp_release_idle", 32'({busy, digest_valid, blk_ready}), 32'b001);
      chk32("ld_work_count_1", 32'(n_ld_work), 32'd1);

      // Two-block NIST message
      blkw = BLK2_1;
      send_block(1'b0);
      n = 1;
      while (!blk_ready && n < 200) begin @(negedge CLK); n++; end
      chk32("nonlast_block_cycles", 32'(n), 32'd67);
      blkw = BLK2_2;
      exp_q.push_back(DIG_2BLK);
      send_block(1'b1);
      chk32("blk2_ld_work", 32'(ld_work), 32'd1);
      chk32("blk2_init_sel", 32'(init_sel), 32'd0);
      chk32("blk2_hash_init", 32'(hash_init), 32'd0);
      digest_ready = 1'b1;
      n = 0;
      while (!digest_valid && n < 200) begin @(negedge CLK); n++; end
      chk32("blk2_digest_valid", 32'(digest_valid), 32'd1);
      @(negedge CLK);
      chk32("blk2_idle_after", 32'(busy), 32'd0);
      digest_ready = 1'b0;

      // Asynchronous reset in the middle of the rounds
      blkw = BLK_ABC;
      send_block(1'b1);
      repeat (20) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk32("arst_state", 32'({busy, rnd_en, blk_ready}), 32'b001);
      chk32("arst_rnd_idx", 32'(rnd_idx), 32'd0);
      chk32("arst_k_t", k_t, 32'h428a2f98);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      // Abort during the second block of a message forgets the chaining context
      blkw = BLK2_1;
      send_block(1'b0);
      n = 1;
      while (!blk_ready && n < 200) begin @(negedge CLK); n++; end
      blkw = BLK2_2;
      send_block(1'b1);
      chk32("abort_pre_init_sel", 32'(init_sel), 32'd0);
      repeat (31) @(negedge CLK);
      chk32("abort_at_idx30", 32'(rnd_idx), 32'd30);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      chk32("abort_idle", 32'({busy, rnd_en, blk_ready}), 32'b001);
      chk32("abort_rnd_idx", 32'(rnd_idx), 32'd0);
      abort = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
      @(negedge CLK);
      abort = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
      chk32("abort_beats_valid", 32'({busy, ld_work}), 32'd0);

      blkw = BLK_ABC;
      exp_q.push_back(DIG_ABC);
      send_block(1'b1);
      chk32("post_abort_init_sel", 32'(init_sel), 32'd1);
      chk32("post_abort_hash_init", 32'(hash_init), 32'd1);
      digest_ready = 1'b1;
      n = 0;
      while (!digest_valid && n < 200) begin @(negedge CLK); n++; end
      chk32("post_abort_digest_valid", 32'(digest_valid), 32'd1);
      @(negedge CLK);
      digest_ready = 1'b0;
      chk32("ld_work_count_total", 32'(n_ld_work), 32'd7);

      // Reduced-round build timing
      chk32("r8_blk_ready", 32'(br8), 32'd1);
      bv8 = 1'b1; dr8 = 1'b1;
      @(negedge CLK);
      bv8 = 1'b0;
      nr = 0; hc = 0; dc = 0;
      for (int c = 1; c <= 13; c++) begin
         if (re8) nr++;
         if (lh8) hc = c;
         if (dv8 && dc == 0) dc = c;
         @(negedge CLK);
      end
      chk32("r8_rnd_count", 32'(nr), 32'd8);
      chk32("r8_update_cycle", 32'(hc), 32'd10);
      chk32("r8_digest_cycle", 32'(dc), 32'd11);
      chk32("r8_idle_after", 32'({busy8, br8}), 32'b01);
      dr8 = 1'b0;

      chk32("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
